// File: rtl/adc_acq_ctrl.sv
// rtl/adc_acq_ctrl.sv - triggered multi-channel ADC capture controller (optional ADC_ACQ_TEST_PATTERN_EN lane pattern)
module adc_acq_ctrl #(
    parameter int NCH   = 4,
    parameter int SPC   = 8,
    parameter int SW    = 12,
    parameter int LEN_W = 14,
    parameter int DLY_W = 20
) (
    input  logic                    clk_125M,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    trig_i,
    input  logic [LEN_W-1:0]        wave_len_i,
    input  logic [LEN_W-1:0]        cycle_i,
    input  logic [DLY_W-1:0]        delay_i,
    input  logic [NCH-1:0]          ch_mask_i,
    input  logic                    prog_full,
    input  logic [NCH*SPC*SW-1:0]   ch_data_i,
    output logic [NCH*SPC*16-1:0]   adc_data_o,
    output logic                    adc_data_valid_o,
    output logic                    trig_fb,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   trig_prev;
    logic [LEN_W-1:0]       wave_len_q;
    logic [LEN_W-1:0]       cycle_q;
    logic [DLY_W-1:0]       delay_q;
    logic [NCH-1:0]         ch_mask_q;
    logic [LEN_W-1:0]       beat_cnt;
    logic [DLY_W-1:0]       dly_cnt;
    logic [LEN_W-1:0]       cyc_cnt;
    logic [NCH*SPC*16-1:0]  beat_fmt;

    logic trig_edge;
    logic start_ok;
    logic beat_last;
    logic dly_last;
    logic cyc_last;
    logic capture_beat;

    // Both counts must be nonzero for an arm request to be meaningful.
    assign trig_edge    = trig_i & ~trig_prev;
    assign start_ok     = start_i && (wave_len_i != '0) && (cycle_i != '0);
    assign beat_last    = (beat_cnt == wave_len_q - LEN_W'(1));
    assign dly_last     = (dly_cnt == delay_q - DLY_W'(1));
    assign cyc_last     = ((cyc_cnt + LEN_W'(1)) == cycle_q);
    assign capture_beat = (state == S_CAPTURE) && !prog_full && !abort_i;

    // State register.
    always_ff @(posedge clk_125M or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_ok) state_nxt = S_ARMED;
                S_ARMED:   if (trig_edge) state_nxt = (delay_q == '0) ? S_CAPTURE : S_DELAY;
                S_DELAY:   if (dly_last) state_nxt = S_CAPTURE;
                S_CAPTURE: if (beat_last) state_nxt = cyc_last ? S_DONE : S_ARMED;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_o  = (state != S_IDLE);
        done_o  = (state == S_DONE);
        trig_fb = (state == S_ARMED) && trig_edge && !abort_i;
    end

    // Trigger history, latched configuration, counters and the sticky overflow flag.
    always_ff @(posedge clk_125M or posedge reset) begin
        if (reset) begin
            trig_prev  <= 1'b0;
            wave_len_q <= '0;
            cycle_q    <= '0;
            delay_q    <= '0;
            ch_mask_q  <= '0;
            beat_cnt   <= '0;
            dly_cnt    <= '0;
            cyc_cnt    <= '0;
            overflow_o <= 1'b0;
        end else begin
            trig_prev <= trig_i;
            if (state == S_IDLE && start_ok && !abort_i) begin
                wave_len_q <= wave_len_i;
                cycle_q    <= cycle_i;
                delay_q    <= delay_i;
                ch_mask_q  <= ch_mask_i;
                cyc_cnt    <= '0;
                overflow_o <= 1'b0;
            end
            dly_cnt  <= (state == S_DELAY) ? dly_cnt + DLY_W'(1) : '0;
            beat_cnt <= (state == S_CAPTURE) ? beat_cnt + LEN_W'(1) : '0;
            if (state == S_CAPTURE && beat_last && !abort_i) begin
                cyc_cnt <= cyc_cnt + LEN_W'(1);
            end
            if (state == S_CAPTURE && prog_full) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Lane formatting: masked channels are zero, enabled lanes widen to 16 bits.
    always_comb begin
        beat_fmt = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < SPC; s++) begin
                if (ch_mask_q[c]) begin
`ifdef ADC_ACQ_TEST_PATTERN_EN
                    beat_fmt[(c*SPC+s)*16 +: 16] = {4'(c), beat_cnt[11:0]};
`else
                    beat_fmt[(c*SPC+s)*16 +: 16] =
                        16'($signed(ch_data_i[(c*SPC+s)*SW +: SW]));
`endif
                end
            end
        end
    end

    // Output beat register: one clock after each accepted capture clock.
    always_ff @(posedge clk_125M or posedge reset) begin
        if (reset) begin
            adc_data_o       <= '0;
            adc_data_valid_o <= 1'b0;
        end else begin
            adc_data_valid_o <= capture_beat;
            if (capture_beat) begin
                adc_data_o <= beat_fmt;
            end
        end
    end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb/tb_adc_acq_ctrl.sv - randomized timeline-model bench for adc_acq_ctrl
module tb_adc_acq_ctrl;

    localparam int N = 24576;

    logic         clk_125M = 1'b0;
    logic         reset = 1'b1;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         trig_i = 1'b0;
    logic [13:0]  wave_len_i = '0;
    logic [13:0]  cycle_i = '0;
    logic [19:0]  delay_i = '0;
    logic [3:0]   ch_mask_i = '0;
    logic         prog_full = 1'b0;
    logic [383:0] ch_data_i = '0;
    logic [511:0] adc_data_o;
    logic         adc_data_valid_o;
    logic         trig_fb;
    logic         busy_o;
    logic         done_o;
    logic         overflow_o;

    adc_acq_ctrl dut (
        .clk_125M(clk_125M), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .trig_i(trig_i), .wave_len_i(wave_len_i), .cycle_i(cycle_i), .delay_i(delay_i),
        .ch_mask_i(ch_mask_i), .prog_full(prog_full), .ch_data_i(ch_data_i),
        .adc_data_o(adc_data_o), .adc_data_valid_o(adc_data_valid_o), .trig_fb(trig_fb),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    always #4 clk_125M = ~clk_125M;

    // Planned stimulus per clock.
    logic         in_start[N], in_abort[N], in_trig[N], in_pf[N], in_rst[N];
    logic [13:0]  in_wl[N], in_cy[N];
    logic [19:0]  in_dly[N];
    logic [3:0]   in_mask[N];
    logic [383:0] in_data[N];
    // Expected observation per clock.
    logic         exp_valid[N], exp_fb[N], exp_done[N], exp_busy[N], is_cap[N], acc_start[N];
    logic [511:0] exp_data[N];

    int pc;
    int cur_t;
    int n_checks = 0;
    int n_errors = 0;
    logic m_ovf;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s clk=%0d got=%0h expected=%0h", tag, cur_t, got, exp);
        end
    endtask

    function automatic logic [511:0] fmt_beat(input logic [383:0] d, input logic [3:0] m, input int idx);
        logic [511:0] r;
        int v;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 8; s++) begin
                if (m[c]) begin
`ifdef ADC_ACQ_TEST_PATTERN_EN
                    v = c * 4096 + (idx % 4096);
`else
                    v = int'(d[(c*8+s)*12 +: 12]);
                    if (v >= 2048) v = v + 'hF000;
`endif
                    r[(c*8+s)*16 +: 16] = 16'(v);
                end
            end
        end
        return r;
    endfunction

    // Lay out one acquisition on the timeline from the behavioural rules.
    task automatic plan_acq(input int wl, input int cy, input int dly, input logic [3:0] mask,
                            input int pf_mode, input bit d800, input int abort_rel, input int rst_rel);
        int gap, s_clk, t, e, e0, c0, c0_first, d_clk, w, tc, a, r, need;
        logic pf;
        logic [383:0] dv;
        need = 8 + cy * (6 + dly + wl);
        if (pc + need >= N) begin
            $display("FAIL plan_overflow clk=%0d got=%0d expected=%0d", pc, pc + need, N);
            $fatal(1, "timeline exhausted");
        end
        for (int i = pc; i < pc + need; i++) begin
            in_wl[i] = 14'($urandom_range(1, 7));
            in_cy[i] = 14'($urandom_range(1, 3));
            in_dly[i] = 20'($urandom_range(0, 7));
            in_mask[i] = 4'($urandom);
        end
        gap = $urandom_range(2, 4);
        if ($urandom_range(0, 1) == 1) in_trig[pc] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            in_start[pc + 1] = 1'b1;
            if ($urandom_range(0, 1) == 1) in_wl[pc + 1] = '0;
            else in_cy[pc + 1] = '0;
        end
        s_clk = pc + gap;
        in_start[s_clk] = 1'b1;
        acc_start[s_clk] = 1'b1;
        in_wl[s_clk] = 14'(wl);
        in_cy[s_clk] = 14'(cy);
        in_dly[s_clk] = 20'(dly);
        in_mask[s_clk] = mask;
        t = s_clk + 1;
        e0 = -1;
        c0_first = -1;
        for (int k = 0; k < cy; k++) begin
            w = $urandom_range(0, 3);
            e = t + w;
            in_trig[e] = 1'b1;
            exp_fb[e] = 1'b1;
            if (e0 < 0) e0 = e;
            if (dly >= 3) in_trig[e + 2] = 1'b1;
            c0 = e + dly + 1;
            if (c0_first < 0) c0_first = c0;
            for (int j = 0; j < wl; j++) begin
                tc = c0 + j;
                for (int q = 0; q < 12; q++) dv[q*32 +: 32] = $urandom;
                if (d800) dv = {32{12'h800}};
                in_data[tc] = dv;
                is_cap[tc] = 1'b1;
                pf = (pf_mode == 1) ? ($urandom_range(0, 4) == 0) : (pf_mode == 2 && j == 1);
                in_pf[tc] = pf;
                if (!pf) begin
                    exp_valid[tc + 1] = 1'b1;
                    exp_data[tc + 1] = fmt_beat(dv, mask, j);
                end
                if (wl >= 3 && j == 1) in_trig[tc] = 1'b1;
            end
            t = c0 + wl;
        end
        d_clk = t;
        exp_done[d_clk] = 1'b1;
        in_start[d_clk] = 1'b1;
        for (int i = s_clk + 1; i <= d_clk; i++) exp_busy[i] = 1'b1;
        if (abort_rel >= 0) begin
            a = e0 + abort_rel;
            if (a > d_clk - 1) a = d_clk - 1;
            in_abort[a] = 1'b1;
            in_pf[a] = 1'b0;
            exp_fb[a] = 1'b0;
            for (int i = a + 1; i <= d_clk + 1; i++) begin
                exp_valid[i] = 1'b0; exp_fb[i] = 1'b0; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
                is_cap[i] = 1'b0; in_trig[i] = 1'b0; in_start[i] = 1'b0;
            end
        end
        if (rst_rel >= 0) begin
            r = c0_first + rst_rel;
            in_rst[r] = 1'b1;
            in_rst[r + 1] = 1'b1;
            for (int i = r; i <= d_clk + 1; i++) begin
                exp_valid[i] = 1'b0; exp_fb[i] = 1'b0; exp_done[i] = 1'b0; exp_busy[i] = 1'b0;
                is_cap[i] = 1'b0; in_trig[i] = 1'b0; in_start[i] = 1'b0;
            end
        end
        pc = d_clk + 2;
    endtask

    initial begin
        int wl, cy, dly, ab, rs;
        for (int i = 0; i < N; i++) begin
            in_start[i] = 0; in_abort[i] = 0; in_trig[i] = 0; in_pf[i] = 0; in_rst[i] = 0;
            in_wl[i] = '0; in_cy[i] = '0; in_dly[i] = '0; in_mask[i] = '0; in_data[i] = '0;
            exp_valid[i] = 0; exp_fb[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
            is_cap[i] = 0; acc_start[i] = 0; exp_data[i] = '0;
        end
        in_rst[0] = 1'b1;
        in_rst[1] = 1'b1;
        pc = 2;
        plan_acq(4, 1, 0, 4'hF, 0, 1'b0, -1, -1);
        plan_acq(3, 2, 10, 4'hF, 0, 1'b0, -1, -1);
        plan_acq(4, 1, 2, 4'hF, 2, 1'b0, -1, -1);
        plan_acq(2, 1, 0, 4'b0101, 0, 1'b1, -1, -1);
        plan_acq(3, 1, 10, 4'hF, 0, 1'b0, 3, -1);
        plan_acq(5, 1, 2, 4'hF, 1, 1'b0, -1, 2);
        for (int n = 0; n < 40; n++) begin
            wl = $urandom_range(1, 6);
            cy = $urandom_range(1, 3);
            dly = $urandom_range(0, 5);
            ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, wl + dly + 2) : -1;
            rs = (ab < 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, wl - 1) : -1;
            plan_acq(wl, cy, dly, 4'($urandom), 1, 1'b0, ab, rs);
        end
        plan_acq(16383, 1, 1, 4'hF, 1, 1'b0, -1, -1);

        m_ovf = 1'b0;
        for (int t = 0; t < pc; t++) begin
            @(posedge clk_125M);
            #1;
            reset = in_rst[t];
            start_i = in_start[t];
            abort_i = in_abort[t];
            trig_i = in_trig[t];
            prog_full = in_pf[t];
            wave_len_i = in_wl[t];
            cycle_i = in_cy[t];
            delay_i = in_dly[t];
            ch_mask_i = in_mask[t];
            ch_data_i = in_data[t];
            @(negedge clk_125M);
            cur_t = t;
            if (in_rst[t]) m_ovf = 1'b0;
            check("valid", 512'(adc_data_valid_o), 512'(exp_valid[t]));
            check("trig_fb", 512'(trig_fb), 512'(exp_fb[t]));
            check("done", 512'(done_o), 512'(exp_done[t]));
            check("busy", 512'(busy_o), 512'(exp_busy[t]));
            check("overflow", 512'(overflow_o), 512'(m_ovf));
            if (exp_valid[t]) check("data", adc_data_o, exp_data[t]);
            if (in_rst[t]) check("reset_data", adc_data_o, 512'(0));
            if (in_rst[t]) m_ovf = 1'b0;
            else if (acc_start[t]) m_ovf = 1'b0;
            else if (is_cap[t] && in_pf[t]) m_ovf = 1'b1;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
